// File: rtl/approx_add_seq_if.sv
// approx_add_seq_if -- operand/result handshake bundle for approx_add_seq.
//   Operand side : in_valid, in_ready, a, b, approx_chunks
//   Result side  : out_valid, out_ready, sum, cout
//   Status       : busy
// The master modport is the operand source and the result sink.
// The slave modport is the sequencer itself.
interface approx_add_seq_if #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int AW     = $clog2(NCHUNK + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [AW-1:0]    approx_chunks;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, approx_chunks, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, approx_chunks, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/approx_add_seq.sv
// approx_add_seq -- WIDTH-bit adder built by stepping one CHUNK-bit slice
// across the operands, LSB chunk first, one chunk per clock.
// The low approx_chunks chunks use an OR slice. The rest use an exact
// ripple slice.
//   clk, rst : clock, synchronous active-high reset
//   bus      : approx_add_seq_if.slave
//              operands in (valid/ready), result out (valid/ready), busy
// WIDTH must be a multiple of CHUNK.
module approx_add_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic              clk,
  input  logic              rst,
  approx_add_seq_if.slave   bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int AW     = $clog2(NCHUNK + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [AW-1:0] LAST_IDX = AW'(NCHUNK - 1);
  localparam logic [AW-1:0] MAX_APX  = AW'(NCHUNK);

  logic [1:0]       state;
  logic [WIDTH-1:0] aReg, bReg, sumReg;
  logic [AW-1:0]    nApprox;
  logic [AW-1:0]    idx;
  logic             carry, coutReg;

  logic [CHUNK-1:0] aSl, bSl, sl;
  logic [CHUNK:0]   exact;
  logic             isApprox, cNext;

  // Single shared slice: the chunk is selected by idx.
  always_comb begin
    aSl      = aReg[idx*CHUNK +: CHUNK];
    bSl      = bReg[idx*CHUNK +: CHUNK];
    exact    = {1'b0, aSl} + {1'b0, bSl} + {{CHUNK{1'b0}}, carry};
    isApprox = idx < nApprox;
    // The approximate slice drops the incoming carry. It still forwards an
    // MSB-generate so the next exact chunk sees a plausible carry.
    sl       = isApprox ? (aSl | bSl) : exact[CHUNK-1:0];
    cNext    = isApprox ? (aSl[CHUNK-1] & bSl[CHUNK-1]) : exact[CHUNK];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      aReg    <= '0;
      bReg    <= '0;
      nApprox <= '0;
      idx     <= '0;
      carry   <= 1'b0;
      sumReg  <= '0;
      coutReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            aReg    <= bus.a;
            bReg    <= bus.b;
            nApprox <= (bus.approx_chunks > MAX_APX) ? MAX_APX : bus.approx_chunks;
            idx     <= '0;
            carry   <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          sumReg[idx*CHUNK +: CHUNK] <= sl;
          carry <= cNext;
          if (idx == LAST_IDX) begin
            coutReg <= cNext;
            idx     <= '0;
            state   <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // in_ready is masked by rst so nothing can be accepted on a reset edge.
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.sum       = sumReg;
  assign bus.cout      = coutReg;
endmodule

// File: tb/tb_approx_add_seq.sv
module tb_approx_add_seq;
  localparam int W = 16;
  localparam int C = 4;
  localparam int N = W / C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  approx_add_seq_if #(.WIDTH(W), .CHUNK(C)) bus();
  approx_add_seq #(.WIDTH(W), .CHUNK(C)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  logic [16:0] expQ[$];
  int accQ[$];
  bit monOn = 1'b0;
  logic prevOv = 1'b0;
  int readyMode = 1;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  // Reference: the low n chunks are a plain OR. The remaining high part is an
  // ordinary integer add. Its carry-in is the generate of bit k-1.
  // Bit 16 of the assembled word is cout.
  function automatic logic [16:0] refAdd(input logic [15:0] av, input logic [15:0] bv, input int nIn);
    int n;
    int k;
    logic [31:0] a32, b32, lowMask, cin, upper, res;
    n = (nIn > N) ? N : nIn;
    k = n * C;
    a32 = {16'b0, av};
    b32 = {16'b0, bv};
    lowMask = (32'd1 << k) - 32'd1;
    cin = (k == 0) ? 32'd0 : (((a32 >> (k - 1)) & (b32 >> (k - 1))) & 32'd1);
    upper = (a32 >> k) + (b32 >> k) + cin;
    res = (upper << k) | ((a32 | b32) & lowMask);
    return res[16:0];
  endfunction

  // Result sink: random, always-ready, or hold low for 3 cycles of out_valid.
  initial begin
    int dv;
    dv = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.out_valid) dv++; else dv = 0;
      case (readyMode)
        0: bus.out_ready = 1'($urandom_range(0, 1));
        1: bus.out_ready = 1'b1;
        default: bus.out_ready = (dv > 3);
      endcase
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (monOn) begin
      chk("inReadyRule", 32'(bus.in_ready), 32'(!bus.busy && !rst));
      if (bus.out_valid) chk("busyWithValid", 32'(bus.busy), 32'd1);
      if (bus.out_valid && !prevOv) begin
        if (accQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spuriousOutValid actual=1 expected=0 (cycle %0d)", cycle);
        end else begin
          chk("latency", 32'(cycle - accQ[0]), 32'(N));
        end
      end
      if (bus.out_valid && expQ.size() > 0) begin
        chk("sum", 32'(bus.sum), 32'(expQ[0][15:0]));
        chk("cout", 32'(bus.cout), 32'(expQ[0][16]));
        if (bus.out_ready) begin
          void'(expQ.pop_front());
          void'(accQ.pop_front());
        end
      end
      prevOv = bus.out_valid;
    end
  end

  task automatic sendOp(input logic [15:0] av, input logic [15:0] bv, input logic [2:0] n, input bit junk);
    int t;
    t = 0;
    @(negedge clk);
    bus.a = av;
    bus.b = bv;
    bus.approx_chunks = n;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      chk("acceptTimeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    expQ.push_back(refAdd(av, bv, int'(n)));
    accQ.push_back(cycle + 1);
    @(posedge clk);
    #1;
    if (junk) begin
      // Keep offering different operands; they must be ignored.
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      bus.approx_chunks = 3'($urandom);
    end else begin
      bus.in_valid = 1'b0;
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(bus.out_valid && bus.out_ready) && t < 200);
    bus.in_valid = 1'b0;
    if (!(bus.out_valid && bus.out_ready)) chk("drainTimeout", 32'd0, 32'd1);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.approx_chunks = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstInReady", 32'(bus.in_ready), 32'd0);
    chk("rstOutValid", 32'(bus.out_valid), 32'd0);
    chk("rstBusy", 32'(bus.busy), 32'd0);
    chk("rstSum", 32'(bus.sum), 32'd0);
    chk("rstCout", 32'(bus.cout), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("inReadyAfterRst", 32'(bus.in_ready), 32'd1);
    monOn = 1'b1;

    readyMode = 1;
    sendOp(16'h00FF, 16'h0001, 3'd0, 1'b0);
    sendOp(16'hFFFF, 16'h0001, 3'd0, 1'b0);
    sendOp(16'h0008, 16'h0008, 3'd1, 1'b0);
    sendOp(16'h00FF, 16'h0001, 3'd1, 1'b0);
    sendOp(16'h1234, 16'h4321, 3'd7, 1'b0);
    sendOp(16'h8000, 16'h8000, 3'd4, 1'b0);

    // Backpressure with junk operands offered during RUN and DONE.
    readyMode = 2;
    sendOp(16'h0F0F, 16'h0101, 3'd2, 1'b1);
    readyMode = 1;
    sendOp(16'h7FFF, 16'h0001, 3'd0, 1'b0);

    // Reset during the second RUN cycle.
    @(negedge clk);
    bus.a = 16'hAAAA;
    bus.b = 16'h5555;
    bus.approx_chunks = 3'd0;
    bus.in_valid = 1'b1;
    chk("abortAcceptReady", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abortOutValid", 32'(bus.out_valid), 32'd0);
    chk("abortSum", 32'(bus.sum), 32'd0);
    chk("abortCout", 32'(bus.cout), 32'd0);
    chk("abortBusy", 32'(bus.busy), 32'd0);
    chk("abortInReady", 32'(bus.in_ready), 32'd1);
    repeat (10) @(negedge clk);
    sendOp(16'h0003, 16'h0004, 3'd0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      readyMode = int'($urandom_range(0, 2));
      sendOp(16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    chk("queueDrained", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
